// File: rtl/data_mem_mp.sv
// Multi-port PE data memory: three burst write streams plus an instruction-addressed
// write-back, NRD instruction read ports and one auto-incrementing stream read port.
module data_mem_mp #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned DEPTH      = 256,
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned NRD        = 2,
  parameter int unsigned WB_DELAY   = 5,
  parameter int unsigned LOAD_BASE  = 0,
  parameter int unsigned SHIFT_BASE = 32,
  parameter int unsigned TX_BASE    = 160,
  parameter int unsigned STRM_BASE  = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wea,
  input  logic                       web,
  input  logic                       wec,
  input  logic                       wed,
  input  logic [DATA_W-1:0]          dina,
  input  logic [DATA_W-1:0]          dinb,
  input  logic                       err_clr,
  input  logic                       rea,
  input  logic [(NRD+1)*ADDR_W-1:0]  inst,
  input  logic                       rec,
  output logic [NRD*DATA_W-1:0]      dout,
  output logic                       dout_v,
  output logic [DATA_W-1:0]          douts,
  output logic                       douts_v,
  output logic                       wb_conflict
);

  localparam int unsigned NP      = NRD + 1;
  localparam int unsigned SP      = NRD;
  localparam int unsigned RD_LAT  = 3;

  localparam logic [ADDR_W-1:0] LOAD_B  = ADDR_W'(LOAD_BASE);
  localparam logic [ADDR_W-1:0] SHIFT_B = ADDR_W'(SHIFT_BASE);
  localparam logic [ADDR_W-1:0] TX_B    = ADDR_W'(TX_BASE);
  localparam logic [ADDR_W-1:0] STRM_B  = ADDR_W'(STRM_BASE);

  logic [ADDR_W-1:0] ptr_a, ptr_b, ptr_c, ptr_s;
  logic [ADDR_W-1:0] hold_q, hold_next;
  logic [ADDR_W-1:0] wb_sr [WB_DELAY];
  logic [ADDR_W-1:0] wb_tap;

  logic              win_a, win_b, win_c, win_d, any_req, wb_drop;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  logic              we_q;
  logic [ADDR_W-1:0] wa_q;
  logic [DATA_W-1:0] wd_q;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] ra_q [NP];
  logic [DATA_W-1:0] rd_q [NP];
  logic [DATA_W-1:0] pd_q [NP];
  logic [RD_LAT-2:0] iv_q, sv_q;
  logic              iv0_q, sv0_q;

  // Write arbitration: fixed priority LOAD > shift > TX > write-back
  always_comb begin
    win_a   = wea;
    win_b   = web & ~wea;
    win_c   = wec & ~wea & ~web;
    win_d   = wed & ~(wea | web | wec);
    any_req = wea | web | wec | wed;
    wb_drop = wed & (wea | web | wec);
    wr_addr = '0;
    wr_data = dina;
    if (win_a) begin
      wr_addr = ptr_a;
    end else if (win_b) begin
      wr_addr = ptr_b;
    end else if (win_c) begin
      wr_addr = ptr_c;
    end else if (win_d) begin
      wr_addr = wb_tap;
      wr_data = dinb;
    end
  end

  // Burst pointers and write pipeline register; pointers rebase when every source is idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_a <= LOAD_B;
      ptr_b <= SHIFT_B;
      ptr_c <= TX_B;
      we_q  <= 1'b0;
      wa_q  <= '0;
      wd_q  <= '0;
    end else begin
      we_q <= any_req;
      wa_q <= wr_addr;
      wd_q <= wr_data;
      if (!any_req) begin
        ptr_a <= LOAD_B;
        ptr_b <= SHIFT_B;
        ptr_c <= TX_B;
      end else begin
        if (win_a) ptr_a <= ptr_a + ADDR_W'(1);
        if (win_b) ptr_b <= ptr_b + ADDR_W'(1);
        if (win_c) ptr_c <= ptr_c + ADDR_W'(1);
      end
    end
  end

  // The chain samples the hold register's next value so the tap lines up with
  // the rea accepted exactly WB_DELAY edges before the write-back edge
  always_comb begin
    hold_next = rea ? inst[ADDR_W-1:0] : hold_q;
    wb_tap    = wb_sr[WB_DELAY-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q <= '0;
      for (int i = 0; i < int'(WB_DELAY); i++) wb_sr[i] <= '0;
    end else begin
      hold_q   <= hold_next;
      wb_sr[0] <= hold_next;
      for (int i = 1; i < int'(WB_DELAY); i++) wb_sr[i] <= wb_sr[i-1];
    end
  end

  // Sticky conflict flag; a new drop outranks a simultaneous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_conflict <= 1'b0;
    end else if (wb_drop) begin
      wb_conflict <= 1'b1;
    end else if (err_clr) begin
      wb_conflict <= 1'b0;
    end
  end

  // Storage: single write port, registered read per port (read-first)
  always_ff @(posedge clk) begin
    if (we_q) mem[wa_q] <= wd_q;
  end

  for (genvar p = 0; p < int'(NP); p++) begin : g_rd
    always_ff @(posedge clk) begin
      rd_q[p] <= mem[ra_q[p]];
    end
  end

  // Read address capture and stream pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < int'(NP); k++) ra_q[k] <= '0;
      ptr_s <= STRM_B;
      iv0_q <= 1'b0;
      sv0_q <= 1'b0;
    end else begin
      iv0_q <= rea;
      sv0_q <= rec;
      if (rea) begin
        for (int k = 0; k < int'(NRD); k++) ra_q[k] <= inst[(k+1)*ADDR_W +: ADDR_W];
      end
      if (rec) begin
        ra_q[SP] <= ptr_s;
        ptr_s    <= ptr_s + ADDR_W'(1);
      end else begin
        ptr_s    <= STRM_B;
      end
    end
  end

  // Read data pipeline and output registers; outputs hold when not valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iv_q    <= '0;
      sv_q    <= '0;
      for (int k = 0; k < int'(NP); k++) pd_q[k] <= '0;
      dout    <= '0;
      dout_v  <= 1'b0;
      douts   <= '0;
      douts_v <= 1'b0;
    end else begin
      iv_q    <= {iv_q[RD_LAT-3:0], iv0_q};
      sv_q    <= {sv_q[RD_LAT-3:0], sv0_q};
      for (int k = 0; k < int'(NP); k++) pd_q[k] <= rd_q[k];
      dout_v  <= iv_q[RD_LAT-2];
      douts_v <= sv_q[RD_LAT-2];
      if (iv_q[RD_LAT-2]) begin
        for (int k = 0; k < int'(NRD); k++) dout[k*DATA_W +: DATA_W] <= pd_q[k];
      end
      if (sv_q[RD_LAT-2]) douts <= pd_q[SP];
    end
  end

endmodule

// File: tb/tb_data_mem_mp.sv
// Directed bench for data_mem_mp; a second instance with bases at DEPTH-1 covers wrap.
module tb_data_mem_mp;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 8;
  localparam int unsigned NR = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            wea, web, wec, wed, err_clr, rea, rec;
  logic [DW-1:0]   dina, dinb;
  logic [3*AW-1:0] inst;
  logic [NR*DW-1:0] dout, w_dout;
  logic            dout_v, w_dout_v, douts_v, w_douts_v, wb_conflict, w_wb_conflict;
  logic [DW-1:0]   douts, w_douts;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  data_mem_mp dut (
    .clk(clk), .rst_n(rst_n), .wea(wea), .web(web), .wec(wec), .wed(wed),
    .dina(dina), .dinb(dinb), .err_clr(err_clr), .rea(rea), .inst(inst), .rec(rec),
    .dout(dout), .dout_v(dout_v), .douts(douts), .douts_v(douts_v),
    .wb_conflict(wb_conflict)
  );

  data_mem_mp #(.LOAD_BASE(255), .STRM_BASE(255)) dut_w (
    .clk(clk), .rst_n(rst_n), .wea(wea), .web(web), .wec(wec), .wed(wed),
    .dina(dina), .dinb(dinb), .err_clr(err_clr), .rea(rea), .inst(inst), .rec(rec),
    .dout(w_dout), .dout_v(w_dout_v), .douts(w_douts), .douts_v(w_douts_v),
    .wb_conflict(w_wb_conflict)
  );

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle();
    wea = 0; web = 0; wec = 0; wed = 0; rea = 0; rec = 0; err_clr = 0;
  endtask

  function automatic logic [3*AW-1:0] mk(input logic [AW-1:0] s1, input logic [AW-1:0] s2,
                                          input logic [AW-1:0] d);
    return {s2, s1, d};
  endfunction

  // Issue one read and return positioned just after the edge where dout is valid
  task automatic issue_read(input logic [AW-1:0] s1, input logic [AW-1:0] s2,
                            input logic [AW-1:0] d);
    rea = 1; inst = mk(s1, s2, d);
    step();
    rea = 0;
    step(3);
  endtask

  task automatic test_reset();
    rst_n = 0; idle(); dina = '0; dinb = '0; inst = '0;
    step(2);
    n_chk++; if (dout !== '0) begin n_fail++; $display("FAIL reset_dout: got %h expected 0", dout); end
    n_chk++; if (dout_v !== 1'b0) begin n_fail++; $display("FAIL reset_dout_v: got %b expected 0", dout_v); end
    n_chk++; if (douts_v !== 1'b0) begin n_fail++; $display("FAIL reset_douts_v: got %b expected 0", douts_v); end
    n_chk++; if (wb_conflict !== 1'b0) begin n_fail++; $display("FAIL reset_conflict: got %b expected 0", wb_conflict); end
    rst_n = 1;
  endtask

  task automatic test_load();
    wea = 1;
    for (int i = 0; i < 4; i++) begin
      dina = DW'((i + 1) * 32'h11);
      step();
    end
    wea = 0;
    step();
    issue_read(8'd0, 8'd3, 8'd0);
    n_chk++; if (dout_v !== 1'b1) begin n_fail++; $display("FAIL load_v: got %b expected 1", dout_v); end
    n_chk++; if (dout !== {32'h44, 32'h11}) begin n_fail++; $display("FAIL load_data: got %h expected %h", dout, {32'h44, 32'h11}); end
    step();
    n_chk++; if (dout_v !== 1'b0) begin n_fail++; $display("FAIL load_v_drop: got %b expected 0", dout_v); end
    n_chk++; if (dout !== {32'h44, 32'h11}) begin n_fail++; $display("FAIL load_hold: got %h expected %h", dout, {32'h44, 32'h11}); end
  endtask

  task automatic test_stream_wrap();
    rec = 1;
    step(2);
    rec = 0;
    step(2);
    n_chk++; if (w_douts_v !== 1'b1) begin n_fail++; $display("FAIL wrap_v0: got %b expected 1", w_douts_v); end
    n_chk++; if (w_douts !== 32'h11) begin n_fail++; $display("FAIL wrap_d0: got %h expected 11", w_douts); end
    step();
    n_chk++; if (w_douts !== 32'h22) begin n_fail++; $display("FAIL wrap_d1: got %h expected 22", w_douts); end
    step();
    n_chk++; if (w_douts_v !== 1'b0) begin n_fail++; $display("FAIL wrap_v_end: got %b expected 0", w_douts_v); end
  endtask

  task automatic test_priority();
    wea = 1; web = 1;
    dina = 32'hA1; step();
    dina = 32'hA2; step();
    wea = 0;
    dina = 32'hB1; step();
    dina = 32'hB2; step();
    web = 0;
    step();
    rea = 1; inst = mk(8'd1, 8'd33, 8'd0); step();
    inst = mk(8'd0, 8'd32, 8'd0); step();
    rea = 0;
    step(2);
    n_chk++; if (dout_v !== 1'b1) begin n_fail++; $display("FAIL prio_v0: got %b expected 1", dout_v); end
    n_chk++; if (dout !== {32'hB2, 32'hA2}) begin n_fail++; $display("FAIL prio_rd0: got %h expected %h", dout, {32'hB2, 32'hA2}); end
    step();
    n_chk++; if (dout_v !== 1'b1) begin n_fail++; $display("FAIL prio_v1: got %b expected 1", dout_v); end
    n_chk++; if (dout !== {32'hB1, 32'hA1}) begin n_fail++; $display("FAIL prio_rd1: got %h expected %h", dout, {32'hB1, 32'hA1}); end
  endtask

  task automatic test_stream();
    web = 1;
    for (int i = 0; i < 4; i++) begin
      dina = DW'(i + 1);
      step();
    end
    web = 0;
    step();
    rec = 1;
    step(3);
    for (int i = 0; i < 4; i++) begin
      step();
      rec = 0;
      n_chk++; if (douts_v !== 1'b1) begin n_fail++; $display("FAIL strm_v%0d: got %b expected 1", i, douts_v); end
      n_chk++; if (douts !== DW'(i + 1)) begin n_fail++; $display("FAIL strm_d%0d: got %h expected %h", i, douts, DW'(i + 1)); end
    end
    step();
    n_chk++; if (douts_v !== 1'b0) begin n_fail++; $display("FAIL strm_v_end: got %b expected 0", douts_v); end
    n_chk++; if (douts !== 32'h4) begin n_fail++; $display("FAIL strm_hold: got %h expected 4", douts); end
  endtask

  task automatic test_writeback();
    rea = 1; inst = mk(8'd0, 8'd0, 8'h40); step();
    rea = 0;
    step(4);
    wed = 1; dinb = 32'hABCD; step();
    wed = 0;
    n_chk++; if (wb_conflict !== 1'b0) begin n_fail++; $display("FAIL wb_noconf: got %b expected 0", wb_conflict); end
    issue_read(8'h40, 8'd3, 8'h50);
    n_chk++; if (dout !== {32'h44, 32'hABCD}) begin n_fail++; $display("FAIL wb_data: got %h expected %h", dout, {32'h44, 32'hABCD}); end
    n_chk++; if (wb_conflict !== 1'b0) begin n_fail++; $display("FAIL wb_noconf2: got %b expected 0", wb_conflict); end
  endtask

  task automatic test_conflict();
    rea = 1; inst = mk(8'd0, 8'd0, 8'h40); step();
    rea = 0;
    step(4);
    wea = 1; dina = 32'h77; wed = 1; dinb = 32'h1234; step();
    wea = 0; wed = 0;
    n_chk++; if (wb_conflict !== 1'b1) begin n_fail++; $display("FAIL conf_set: got %b expected 1", wb_conflict); end
    issue_read(8'h40, 8'd0, 8'h40);
    n_chk++; if (dout !== {32'h77, 32'hABCD}) begin n_fail++; $display("FAIL conf_data: got %h expected %h", dout, {32'h77, 32'hABCD}); end
    n_chk++; if (wb_conflict !== 1'b1) begin n_fail++; $display("FAIL conf_sticky: got %b expected 1", wb_conflict); end
    err_clr = 1; wed = 1; web = 1; step();
    wed = 0; web = 0;
    n_chk++; if (wb_conflict !== 1'b1) begin n_fail++; $display("FAIL conf_set_prio: got %b expected 1", wb_conflict); end
    step();
    err_clr = 0;
    n_chk++; if (wb_conflict !== 1'b0) begin n_fail++; $display("FAIL conf_clr: got %b expected 0", wb_conflict); end
  endtask

  task automatic test_async_reset();
    wea = 1;
    dina = 32'hC1; step();
    dina = 32'hC2; step();
    dina = 32'hC3; wed = 1; step();
    wed = 0;
    #2;
    rst_n = 0;
    #1;
    n_chk++; if (dout !== '0) begin n_fail++; $display("FAIL arst_dout: got %h expected 0", dout); end
    n_chk++; if (douts !== '0) begin n_fail++; $display("FAIL arst_douts: got %h expected 0", douts); end
    n_chk++; if (wb_conflict !== 1'b0) begin n_fail++; $display("FAIL arst_conflict: got %b expected 0", wb_conflict); end
    dina = 32'hEE;
    step(2);
    rst_n = 1;
    dina = 32'hD1; step();
    dina = 32'hD2; step();
    wea = 0;
    step();
    issue_read(8'd0, 8'd1, 8'd0);
    n_chk++; if (dout !== {32'hD2, 32'hD1}) begin n_fail++; $display("FAIL arst_restart: got %h expected %h", dout, {32'hD2, 32'hD1}); end
    issue_read(8'd2, 8'h40, 8'd0);
    n_chk++; if (dout !== {32'hABCD, 32'h33}) begin n_fail++; $display("FAIL arst_retain: got %h expected %h", dout, {32'hABCD, 32'h33}); end
  endtask

  initial begin
    test_reset();
    test_load();
    test_stream_wrap();
    test_priority();
    test_stream();
    test_writeback();
    test_conflict();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
